// File: rtl/ahb_resp_mux_pkg.sv
// ahb_resp_mux_pkg: shared AHB-Lite transfer encodings, default-subordinate states and helpers
package ahb_resp_mux_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2} statetype_t;
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ;
  endfunction
endpackage

// File: rtl/ahb_resp_mux_if.sv
// ahb_resp_mux_if: response-path bundle; master = manager/subordinate side, slave = the mux
// Signals: HSELRegions/HTRANS address phase, HREADYOUTS/HRESPS/HRDATAS from subordinates,
// HREADY/HRESP/HRDATA/DecodeErr back to the manager.
interface ahb_resp_mux_if #(parameter int XLEN = 64, parameter int NREGIONS = 14);
  logic [NREGIONS-1:0]      HSELRegions;
  logic [1:0]               HTRANS;
  logic [NREGIONS-1:0]      HREADYOUTS;
  logic [NREGIONS-1:0]      HRESPS;
  logic [NREGIONS*XLEN-1:0] HRDATAS;
  logic                     HREADY;
  logic                     HRESP;
  logic [XLEN-1:0]          HRDATA;
  logic                     DecodeErr;
  modport master (output HSELRegions, HTRANS, HREADYOUTS, HRESPS, HRDATAS,
                  input  HREADY, HRESP, HRDATA, DecodeErr);
  modport slave  (input  HSELRegions, HTRANS, HREADYOUTS, HRESPS, HRDATAS,
                  output HREADY, HRESP, HRDATA, DecodeErr);
endinterface

// File: rtl/ahb_resp_mux_default_sub.sv
// ahb_default_sub: default subordinate giving a two-cycle ERROR response to bad selects
// Ports: clk, reset (sync, active-high), accept (transfer taken this cycle),
// invalid_sel (address-phase select is not a single mapped region), HREADYOUT, HRESP.
module ahb_default_sub
  import ahb_resp_mux_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic accept,
  input  logic invalid_sel,
  output logic HREADYOUT,
  output logic HRESP
);
  statetype_t state, state_n;
  // ERR1 cannot see an accept (HREADY is low), so it always advances to ERR2.
  always_comb state_n = state == ERR1 ? ERR2 : (accept & invalid_sel) ? ERR1 : IDLE;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  assign HREADYOUT = state != ERR1;
  assign HRESP     = state != IDLE;
endmodule

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-Lite manager-side response mux with built-in default subordinate
// Ports: clk, reset (sync, active-high), bus (slave modport): address-phase select and
// HTRANS in, per-subordinate ready/resp/data in, global HREADY/HRESP/HRDATA/DecodeErr out.
module ahb_resp_mux
  import ahb_resp_mux_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREGIONS = 14
) (
  input logic           clk,
  input logic           reset,
  ahb_resp_mux_if.slave bus
);
  logic [NREGIONS-1:0] sel_d;
  logic [XLEN-1:0]     rdata;
  logic accept, addr_bad, sel_valid, sel_err, def_ready, def_resp;
  // A select is usable only if it names exactly one real region; all-zero is a no-op.
  function automatic logic sel_bad(input logic [NREGIONS-1:0] s);
    return |s & ~($onehot(s) & ~s[0]);
  endfunction
  assign accept    = bus.HREADY & is_active(bus.HTRANS);
  assign addr_bad  = sel_bad(bus.HSELRegions);
  assign sel_valid = $onehot(sel_d) & ~sel_d[0];
  assign sel_err   = sel_bad(sel_d);
  always_ff @(posedge clk)
    if (reset) sel_d <= '0;
    else if (accept) sel_d <= bus.HSELRegions;
    else if (bus.HREADY) sel_d <= '0;
  ahb_default_sub u_def (
    .clk         (clk),
    .reset       (reset),
    .accept      (accept),
    .invalid_sel (addr_bad),
    .HREADYOUT   (def_ready),
    .HRESP       (def_resp)
  );
  // AND-OR one-hot mux; only used when sel_d is a valid one-hot, so bit 0 never reaches the output.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREGIONS; i++)
      rdata |= {XLEN{sel_d[i]}} & bus.HRDATAS[i*XLEN +: XLEN];
  end
  assign bus.HRDATA    = sel_valid ? rdata : '0;
  assign bus.HREADY    = sel_valid ? |(sel_d & bus.HREADYOUTS) : sel_err ? def_ready : 1'b1;
  assign bus.HRESP     = sel_valid ? |(sel_d & bus.HRESPS) : sel_err ? def_resp : 1'b0;
  assign bus.DecodeErr = sel_err;
endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux: directed + randomized bench against a data-phase reference model
module tb_ahb_resp_mux;
  import ahb_resp_mux_pkg::*;
  localparam int XLEN = 64;
  localparam int NR   = 14;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  ahb_resp_mux_if #(.XLEN(XLEN), .NREGIONS(NR)) bus ();
  ahb_resp_mux #(.XLEN(XLEN), .NREGIONS(NR)) dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  // Model of the current data phase: kind 0 = none, 1 = region m_reg, 2 = error (m_cnt = cycle 1 or 2)
  int m_kind = 0;
  int m_reg = 0;
  int m_cnt = 0;
  logic e_ready, e_resp, e_de;
  logic [XLEN-1:0] e_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_out();
    e_ready = 1'b1; e_resp = 1'b0; e_de = 1'b0; e_data = '0;
    if (m_kind == 1) begin
      e_ready = bus.HREADYOUTS[m_reg];
      e_resp  = bus.HRESPS[m_reg];
      e_data  = bus.HRDATAS[m_reg*XLEN +: XLEN];
    end else if (m_kind == 2) begin
      e_ready = m_cnt == 2;
      e_resp  = 1'b1;
      e_de    = 1'b1;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_kind = 0;
    end else if (e_ready) begin
      m_kind = 0;
      if (bus.HTRANS[1]) begin
        if ($countones(bus.HSELRegions) == 1 && !bus.HSELRegions[0]) begin
          m_kind = 1;
          for (int k = 1; k < NR; k++) if (bus.HSELRegions[k]) m_reg = k;
        end else if (bus.HSELRegions != '0) begin
          m_kind = 2;
          m_cnt = 1;
        end
      end
    end else if (m_kind == 2) begin
      m_cnt = 2;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_out();
    chk("hready", bus.HREADY, e_ready);
    chk("hresp", bus.HRESP, e_resp);
    chk("hrdata", bus.HRDATA, e_data);
    chk("decodeerr", bus.DecodeErr, e_de);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < NR * XLEN / 32; w++) bus.HRDATAS[w*32 +: 32] = $urandom;
  endtask

  initial begin
    int a, b;
    reset = 1'b1;
    bus.HTRANS = HTRANS_IDLE;
    bus.HSELRegions = '0;
    bus.HREADYOUTS = '1;
    bus.HRESPS = '0;
    rand_data();
    repeat (3) cycle();
    reset = 1'b0;
    repeat (2) cycle();
    // region 3 with two wait states
    bus.HRDATAS[3*XLEN +: XLEN] = 64'hDEADBEEF_CAFEF00D;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HSELRegions = 14'h0008;
    cycle();
    bus.HTRANS = HTRANS_IDLE;
    bus.HSELRegions = '0;
    bus.HREADYOUTS[3] = 1'b0;
    #1 chk("r3_wait", bus.HREADY, 1'b0);
    repeat (2) cycle();
    bus.HREADYOUTS[3] = 1'b1;
    #1;
    chk("r3_ready", bus.HREADY, 1'b1);
    chk("r3_data", bus.HRDATA, 64'hDEADBEEF_CAFEF00D);
    chk("r3_resp", bus.HRESP, 1'b0);
    cycle();
    // unmapped, then region 8 presented during ERR2
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HSELRegions = 14'h0001;
    cycle();
    bus.HTRANS = HTRANS_IDLE;
    bus.HSELRegions = '0;
    #1;
    chk("err1_ready", bus.HREADY, 1'b0);
    chk("err1_resp", bus.HRESP, 1'b1);
    chk("err1_de", bus.DecodeErr, 1'b1);
    cycle();
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HSELRegions = 14'h0100;
    bus.HRDATAS[8*XLEN +: XLEN] = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("err2_ready", bus.HREADY, 1'b1);
    chk("err2_resp", bus.HRESP, 1'b1);
    chk("err2_data", bus.HRDATA, 64'h0);
    cycle();
    bus.HTRANS = HTRANS_IDLE;
    bus.HSELRegions = '0;
    #1;
    chk("r8_data", bus.HRDATA, 64'h0123_4567_89AB_CDEF);
    chk("r8_resp", bus.HRESP, 1'b0);
    chk("r8_de", bus.DecodeErr, 1'b0);
    cycle();
    // multi-hot regions 4 and 5
    bus.HRDATAS[4*XLEN +: XLEN] = 64'h4444_4444_4444_4444;
    bus.HRDATAS[5*XLEN +: XLEN] = 64'h5555_5555_5555_5555;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HSELRegions = 14'h0030;
    cycle();
    bus.HTRANS = HTRANS_IDLE;
    bus.HSELRegions = '0;
    #1 chk("mh_data1", bus.HRDATA, 64'h0);
    repeat (2) cycle();
    // reset during ERR1
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HSELRegions = 14'h0001;
    cycle();
    bus.HTRANS = HTRANS_IDLE;
    bus.HSELRegions = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_ready", bus.HREADY, 1'b1);
    chk("rst_resp", bus.HRESP, 1'b0);
    chk("rst_de", bus.DecodeErr, 1'b0);
    cycle();
    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      reset = $urandom_range(0, 59) == 0;
      bus.HTRANS = 2'($urandom);
      case ($urandom_range(0, 5))
        0: bus.HSELRegions = '0;
        1: bus.HSELRegions = 14'h0001;
        2: begin
          a = $urandom_range(0, NR - 1);
          b = (a + $urandom_range(1, NR - 1)) % NR;
          bus.HSELRegions = (14'h1 << a) | (14'h1 << b);
        end
        default: bus.HSELRegions = 14'h1 << $urandom_range(1, NR - 1);
      endcase
      for (int k = 0; k < NR; k++) bus.HREADYOUTS[k] = $urandom_range(0, 3) != 0;
      bus.HRESPS = 14'($urandom);
      rand_data();
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- Manager-side AHB-Lite response path for the uncore; the counterpart of the region address decode.
- Captures the decoded region one-hot during the address phase and steers the selected subordinate's ready, response and read data back during the data phase.
- Contains the default subordinate: a two-cycle ERROR response for unmapped or multiply-decoded addresses.
- Sits between the uncore subordinates and the bus manager.

Parameters:
- XLEN, 64, read data width in bits.
- NREGIONS, 14, number of select lines; index 0 = unmapped region.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- HSELRegions  input  NREGIONS  address-phase one-hot region select; bit 0 = no region hit
- HTRANS  input  2  manager transfer type
- HREADYOUTS  input  NREGIONS  per-subordinate HREADYOUT; bit 0 ignored
- HRESPS  input  NREGIONS  per-subordinate HRESP; bit 0 ignored
- HRDATAS  input  NREGIONS*XLEN  per-subordinate read data; slice i = [i*XLEN +: XLEN]; slice 0 ignored
- HREADY  output  1  global ready to manager and all subordinates
- HRESP  output  1  response to manager (1 = ERROR)
- HRDATA  output  XLEN  read data to manager
- DecodeErr  output  1  high during any data phase whose capture was not exactly one-hot

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Transfer acceptance:
  - Accept = HREADY & HTRANS[1]; covers NONSEQ/SEQ.
  - IDLE and BUSY are never accepted.
- Data-phase select register SelD (NREGIONS bits):
  - On Accept, SelD <= HSELRegions.
  - Else if HREADY, SelD <= 0.
  - Else hold.
- Data-phase validity: valid iff SelD has exactly one bit set among bits 1..NREGIONS-1 and SelD[0]=0.
- Valid data phase, region i:
  - HREADY = HREADYOUTS[i], HRESP = HRESPS[i], HRDATA = slice i.
  - Purely combinational; zero added latency.
- Invalid, nonzero data phase (SelD[0]=1, or more than one bit set):
  - Handled by the default subordinate FSM.
  - DecodeErr = 1 for the whole data phase.
- SelD == 0: HREADY=1, HRESP=0, HRDATA=0, DecodeErr=0.
- Default subordinate FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on Accept of an invalid select vector.
  - ERR1: HREADY=0, HRESP=1; always -> ERR2 next cycle.
  - ERR2: HREADY=1, HRESP=1.
    - Next state = ERR1 if an invalid transfer is accepted in this same cycle.
    - Otherwise next state = IDLE.
  - HRDATA = 0 in ERR1 and ERR2.
- Manager cancels with IDLE HTRANS during ERR1: no effect on FSM; ERR2 still completes.
- Back-to-back transfers: SelD updates on the HREADY=1 cycle that ends the prior data phase. A valid transfer accepted in ERR2 is steered normally on the next cycle.
- Subordinate wait states: SelD and HRDATA steering held while HREADY=0. The new address phase is not accepted until HREADY=1.
- Reset values: SelD=0, FSM=IDLE, HREADY=1, HRESP=0, HRDATA=0, DecodeErr=0.
- Reset mid-transfer (including ERR1) returns to these values on the next edge. No pending response is replayed.
- HREADY is not a combinational function of HTRANS or HSELRegions; only registered state and subordinate outputs feed it.

Decomposition:
- cvw package:
  - HTRANS encodings: HTRANS_IDLE=2'b00, HTRANS_BUSY=2'b01, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11.
  - Default-subordinate state enum statetype_t {IDLE, ERR1, ERR2}.
- Sub-module ahb_default_sub:
  - Inputs: clk, reset, Accept, invalid-select flag.
  - Outputs: HREADYOUT, HRESP.
  - Contains the FSM.
- ahb_resp_mux keeps SelD, the one-hot check and the steering onehot mux.

Test Plan:
- Reset held 3 cycles, then released with HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0, DecodeErr=0 every cycle.
- NONSEQ with HSELRegions=14'h0008 (region 3), HREADYOUTS[3] low 2 cycles, slice 3 = 64'hDEADBEEF_CAFEF00D -> HREADY=0 for 2 data cycles, then 1 with HRDATA=64'hDEADBEEF_CAFEF00D, HRESP=0.
- NONSEQ with HSELRegions=14'h0001 -> next cycle HREADY=0, HRESP=1; following cycle HREADY=1, HRESP=1; DecodeErr=1 both cycles, HRDATA=0.
- Unmapped transfer, then NONSEQ to region 8 (UART) presented in the ERR2 cycle -> region 8 steered the cycle after ERR2; no extra ERROR cycle.
- Multi-hot HSELRegions=14'h0030 -> ERROR two-cycle sequence with DecodeErr=1; regions 4/5 data never driven out.
- reset asserted in the ERR1 cycle -> next cycle HREADY=1, HRESP=0, FSM IDLE, SelD=0.
